button_latency_meter: RTL

// - Multi-channel successor to the single-button UART round-trip timer.
// - Button rising edge (pre-synchronised) -> marker byte sent on uart_tx.
// - Tick counter runs until any byte arrives on uart_rx, then a multi-byte result frame is sent.
// - Sits between board button edge detectors and the host/DUT UART; instantiates uart_tx and uart_rx internally.

---
 rtl/button_latency_meter.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/button_latency_meter.sv
// button_latency_meter: multi-channel button-to-UART-response latency timer with framed result output
// Ports: clk_100mhz clock; rst_n_sync async active-low reset; button_press_redge[NUM_CH] one-cycle press edges;
//   uart_rx serial in; uart_tx serial out; busy measurement/frame in progress; meas_valid result pulse;
//   meas_ch/meas_count/meas_timeout last measurement. Optional macro FRAME_CHECKSUM_EN appends an XOR byte.
module uart_tx #(
  parameter real SYSCLOCK = 100.0,
  parameter real BAUDRATE = 3.0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       send_trig,
  input  logic [7:0] data,
  output logic       tx,
  output logic       tx_bsy
);
  localparam int CPB = $rtoi(SYSCLOCK / BAUDRATE + 0.5);
  localparam int CW = $clog2(CPB);
  localparam logic [CW-1:0] BLAST = CW'(CPB - 1);
  logic [9:0] shift_q, shift_d;
  logic [3:0] bits_q, bits_d;
  logic [CW-1:0] baud_q, baud_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      shift_q <= '1;
      bits_q <= '0;
      baud_q <= '0;
    end else begin
      shift_q <= shift_d;
      bits_q <= bits_d;
      baud_q <= baud_d;
    end
  always_comb begin
    shift_d = shift_q;
    bits_d = bits_q;
    baud_d = baud_q;
    if (bits_q == 4'd0) begin
      if (send_trig) begin
        shift_d = {1'b1, data, 1'b0};
        bits_d = 4'd10;
        baud_d = '0;
      end
    end else begin
      baud_d = baud_q == BLAST ? '0 : baud_q + 1'b1;
      if (baud_q == BLAST) begin
        shift_d = {1'b1, shift_q[9:1]};
        bits_d = bits_q - 1'b1;
      end
    end
  end
  assign tx = shift_q[0];
  assign tx_bsy = bits_q != 4'd0;
endmodule

// Only byte arrival matters to the meter, so the receiver reports a valid stop bit and no data.
module uart_rx #(
  parameter real SYSCLOCK = 100.0,
  parameter real BAUDRATE = 3.0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic data_valid
);
  localparam int CPB = $rtoi(SYSCLOCK / BAUDRATE + 0.5);
  localparam int CW = $clog2(CPB);
  localparam logic [CW-1:0] BLAST = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);
  logic [1:0] sync_q;
  logic rx_s, busy_q, busy_d, valid_q, valid_d;
  logic [3:0] bits_q, bits_d;
  logic [CW-1:0] baud_q, baud_d;
  assign rx_s = sync_q[1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q <= '1;
      busy_q <= 1'b0;
      valid_q <= 1'b0;
      bits_q <= '0;
      baud_q <= '0;
    end else begin
      sync_q <= {sync_q[0], rx};
      busy_q <= busy_d;
      valid_q <= valid_d;
      bits_q <= bits_d;
      baud_q <= baud_d;
    end
  always_comb begin
    busy_d = busy_q;
    bits_d = bits_q;
    baud_d = baud_q;
    valid_d = 1'b0;
    if (!busy_q) begin
      busy_d = !rx_s;
      bits_d = '0;
      baud_d = '0;
    end else if (baud_q == (bits_q == 4'd0 ? HALF : BLAST)) begin
      baud_d = '0;
      bits_d = bits_q + 1'b1;
      busy_d = !(bits_q == 4'd9 || (bits_q == 4'd0 && rx_s));
      valid_d = bits_q == 4'd9 && rx_s;
    end else
      baud_d = baud_q + 1'b1;
  end
  assign data_valid = valid_q;
endmodule

module button_latency_meter #(
  parameter int  NUM_CH      = 4,
  parameter int  CNT_W       = 16,
  parameter int  TICK_CYCLES = 1000,
  parameter real SYSCLOCK    = 100.0,
  parameter real BAUDRATE    = 3.0
) (
  input  logic              clk_100mhz,
  input  logic              rst_n_sync,
  input  logic [NUM_CH-1:0] button_press_redge,
  input  logic              uart_rx,
  output logic              uart_tx,
  output logic              busy,
  output logic              meas_valid,
  output logic [2:0]        meas_ch,
  output logic [CNT_W-1:0]  meas_count,
  output logic              meas_timeout
);
  localparam int NB = CNT_W / 8;
`ifdef FRAME_CHECKSUM_EN
  localparam int LAST = NB + 1;
`else
  localparam int LAST = NB;
`endif
  localparam logic [2:0] IDX_LAST = 3'(LAST);
  localparam int PW = $clog2(TICK_CYCLES);
  localparam logic [PW-1:0] PLAST = PW'(TICK_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, SEND_MARK, WAIT_RESP, SEND_RESULT} state_t;
  state_t state_q, state_d;
  logic [2:0] ch_q, ch_d, meas_ch_q, meas_ch_d, idx_q, idx_d, low_ch;
  logic [PW-1:0] presc_q, presc_d;
  logic [CNT_W-1:0] count_q, count_d, meas_count_q, meas_count_d;
  logic trig_q, meas_valid_q, meas_valid_d, meas_timeout_q, meas_timeout_d;
  logic send_trig, tx_bsy, rx_valid, tx_ok, hit;
  logic [7:0] tx_byte, hdr;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
  assign csum_d = state_q != SEND_RESULT ? '0 : send_trig ? csum_q ^ tx_byte : csum_q;
  always_ff @(posedge clk_100mhz or negedge rst_n_sync)
    if (!rst_n_sync) csum_q <= '0;
    else csum_q <= csum_d;
`endif
  uart_tx #(.SYSCLOCK(SYSCLOCK), .BAUDRATE(BAUDRATE)) u_tx (
    .clk(clk_100mhz), .rst_n(rst_n_sync), .send_trig(send_trig), .data(tx_byte),
    .tx(uart_tx), .tx_bsy(tx_bsy)
  );
  uart_rx #(.SYSCLOCK(SYSCLOCK), .BAUDRATE(BAUDRATE)) u_rx (
    .clk(clk_100mhz), .rst_n(rst_n_sync), .rx(uart_rx), .data_valid(rx_valid)
  );
  always_comb begin
    low_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (button_press_redge[i]) low_ch = 3'(i);
  end
  // tx_bsy only rises the cycle after a trig, so the previous-trig flag closes that gap
  assign tx_ok = !trig_q && !tx_bsy;
  assign hdr = {4'hC, meas_timeout_q, meas_ch_q};
  always_comb begin
    state_d = state_q;
    ch_d = ch_q;
    presc_d = presc_q;
    count_d = count_q;
    idx_d = idx_q;
    meas_valid_d = 1'b0;
    meas_ch_d = meas_ch_q;
    meas_count_d = meas_count_q;
    meas_timeout_d = meas_timeout_q;
    send_trig = 1'b0;
    tx_byte = {5'b10000, ch_q};
    hit = 1'b0;
    case (state_q)
      IDLE:
        if (|button_press_redge) begin
          ch_d = low_ch;
          presc_d = '0;
          count_d = '0;
          state_d = SEND_MARK;
        end
      // IDLE is only re-entered with the transmitter drained, so the marker never has to wait
      SEND_MARK: begin
        send_trig = 1'b1;
        presc_d = presc_q + 1'b1;
        state_d = WAIT_RESP;
        hit = rx_valid;
      end
      WAIT_RESP: begin
        presc_d = presc_q == PLAST ? '0 : presc_q + 1'b1;
        count_d = presc_q == PLAST && count_q != '1 ? count_q + 1'b1 : count_q;
        hit = rx_valid || count_q == '1;
      end
      SEND_RESULT: begin
`ifdef FRAME_CHECKSUM_EN
        tx_byte = idx_q == 3'd0 ? hdr : idx_q == IDX_LAST ? csum_q : count_q[CNT_W-1 -: 8];
`else
        tx_byte = idx_q == 3'd0 ? hdr : count_q[CNT_W-1 -: 8];
`endif
        send_trig = tx_ok && idx_q <= IDX_LAST;
        if (send_trig) begin
          idx_d = idx_q + 1'b1;
          count_d = idx_q != 3'd0 ? count_q << 8 : count_q;
        end
        if (tx_ok && idx_q > IDX_LAST) state_d = IDLE;
      end
    endcase
    // rx_valid takes priority over saturation, so a same-cycle race reports a real response
    if (hit) begin
      state_d = SEND_RESULT;
      idx_d = '0;
      count_d = count_q;
      meas_valid_d = 1'b1;
      meas_ch_d = ch_q;
      meas_count_d = count_q;
      meas_timeout_d = !rx_valid;
    end
  end
  always_ff @(posedge clk_100mhz or negedge rst_n_sync)
    if (!rst_n_sync) begin
      state_q <= IDLE;
      ch_q <= '0;
      presc_q <= '0;
      count_q <= '0;
      idx_q <= '0;
      trig_q <= 1'b0;
      meas_valid_q <= 1'b0;
      meas_ch_q <= '0;
      meas_count_q <= '0;
      meas_timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q <= ch_d;
      presc_q <= presc_d;
      count_q <= count_d;
      idx_q <= idx_d;
      trig_q <= send_trig;
      meas_valid_q <= meas_valid_d;
      meas_ch_q <= meas_ch_d;
      meas_count_q <= meas_count_d;
      meas_timeout_q <= meas_timeout_d;
    end
  assign busy = state_q != IDLE;
  assign meas_valid = meas_valid_q;
  assign meas_ch = meas_ch_q;
  assign meas_count = meas_count_q;
  assign meas_timeout = meas_timeout_q;
endmodule
